ex_divider: RTL and testbench
=============================

# ex_divider

Multi-cycle 32-bit integer divider in the EX stage, executing MIPS DIV/DIVU on the two operands produced by the ID stage. It computes quotient (LO) and remainder (HI) with a radix-2 restoring algorithm over 32 iterations. It holds the pipeline with a stall request until the result is ready. It discards in-flight work on a pipeline flush.

## Interface

- Parameters: none. The data width is fixed at 32 bits, per `DATA_BUS`.
- Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  the EX instruction is DIV/DIVU; held high while that instruction sits in EX.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; sampled with `start`.
- `operand_1`  in  32  dividend; sampled at acceptance.
- `operand_2`  in  32  divisor; sampled at acceptance.
- `flush`  in  1  cancel any operation; takes priority over `start`.
- `stall_req`  out  1  combinational; holds the pipeline while the divide is not finished.
- `done`  out  1  registered; one-cycle pulse when `hi`/`lo` are valid.
- `hi`  out  32  remainder, registered.
- `lo`  out  32  quotient, registered.

## Operation

- States: IDLE, CALC, DONE.
- IDLE → CALC: on `start=1`, `flush=0`, `operand_2≠0`.
  - Latch the operand magnitudes: two's-complement absolute value when `is_signed`, raw value otherwise.
  - Latch the sign flags: quotient negative = sign(op1) XOR sign(op2); remainder negative = sign(op1). Both flags are 0 when unsigned.
  - Clear the 6-bit iteration counter.
- IDLE → DONE: on `start=1`, `flush=0`, `operand_2=0` (divide by zero).
  - `lo` = 0xFFFFFFFF.
  - `hi` = raw `operand_1`.
  - This result applies regardless of `is_signed`.
- CALC behaviour:
  - 65-bit working register {rem[32:0], quot[31:0]}.
  - Each cycle: shift left 1, trial-subtract the divisor magnitude from rem.
  - If the result is non-negative, keep the difference and set quot[0]=1; otherwise restore and set quot[0]=0.
  - Counter increments each cycle.
  - After iteration 31 (counter = 31): go to DONE.
  - Load `lo` = quot, negated if the quotient-negative flag is set.
  - Load `hi` = rem[31:0], negated if the remainder-negative flag is set.
- DONE → IDLE: unconditionally, next cycle. `start` is ignored in DONE, because it still belongs to the finished instruction.
- Flush: from any state, `flush=1` forces IDLE at the next edge.
  - `done` stays 0.
  - `hi`/`lo` keep their previous values.
- Operand changes after acceptance are ignored.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: magnitude 0x80000000 / 1 gives `lo` = 0x80000000, `hi` = 0. No exception is raised.

## Timing

- Reset (asynchronous, `rst=0`):
  - State = IDLE.
  - `done` = 0, `hi` = 0, `lo` = 0, counter = 0.
  - `stall_req` follows its combinational equation from IDLE.
- `stall_req` = (IDLE & `start` & ~`flush`) | CALC. It is 0 in DONE, so the pipeline advances in the DONE cycle.
- Latency, with `start` first seen in IDLE at cycle 0:
  - CALC occupies cycles 1–32.
  - DONE (`done=1`, results valid) occurs at cycle 33.
  - `stall_req` is high for cycles 0–32 (33 cycles).
- Divide-by-zero latency: `done=1` at cycle 1; `stall_req` high only in cycle 0.
- Back-to-back divides: a new DIV in EX at the cycle after DONE is accepted from IDLE immediately. This gives 34 cycles per divide.
- `done` is registered, so it is never high in the same cycle as `stall_req`.
- Reset asserted mid-CALC: outputs clear immediately (asynchronously), and there is no `done` pulse.

## Test plan

1. DIVU 100 / 7, `start` held → `stall_req` high cycles 0–32; at cycle 33 `done=1`, `lo`=14, `hi`=2; `done` low at cycle 34.
2. DIV 0xFFFFFFF9 (−7) / 2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). DIVU of the same operands → `lo`=0x7FFFFFFC, `hi`=1.
3. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0 at cycle 33. DIV 5 / 0 → `done` at cycle 1, `lo`=0xFFFFFFFF, `hi`=5.
4. Start DIVU 1000/3; assert `flush` at cycle 10 → IDLE at cycle 11, `stall_req`=0 once `start` drops, no `done` pulse, `hi`/`lo` unchanged. Then start 9/3 → `lo`=3, `hi`=0 at cycle 33 after that start.
5. Two consecutive DIVs: 20/6 then 0xFFFFFFEC/6 signed → first result `lo`=3, `hi`=2; second `done` 34 cycles later with `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFE. Verify that the operands changing during CALC have no effect.
6. Assert `rst` low at cycle 15 of a divide → `hi`=`lo`=0 and `done`=0 immediately; after release with `start` low, `stall_req`=0.

Source files
------------

// File: rtl/ex_divider.sv
// ---------------------------------------------------------------------------
// ex_divider
//
// Multi-cycle 32-bit MIPS DIV/DIVU unit for the EX stage. It uses a radix-2
// restoring algorithm over 32 iterations. The remainder is returned on hi and
// the quotient on lo. It holds the pipeline via stall_req until the result is
// ready, and discards in-flight work on flush.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-low reset
//   start      in   1   EX instruction is DIV/DIVU (held while in EX)
//   is_signed  in   1   1 = DIV, 0 = DIVU
//   operand_1  in  32   dividend, sampled at acceptance
//   operand_2  in  32   divisor, sampled at acceptance
//   flush      in   1   cancel any operation (beats start)
//   stall_req  out  1   combinational pipeline hold
//   done       out  1   registered one-cycle result-valid pulse
//   hi         out 32   remainder
//   lo         out 32   quotient
// ---------------------------------------------------------------------------
module ex_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] operand_1,
   input  logic [31:0] operand_2,
   input  logic        flush,
   output logic        stall_req,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  r_state;
   logic [5:0]  r_cnt;
   logic [64:0] r_work;   // {rem[32:0], quot[31:0]}
   logic [31:0] r_div;    // divisor magnitude
   logic        r_qneg;
   logic        r_rneg;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic [31:0] w_mag1;
   logic [31:0] w_mag2;
   logic [33:0] w_sub;
   logic [64:0] w_keep;
   logic [64:0] w_rest;
   logic [64:0] w_next;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   always_comb begin
      w_mag1 = (is_signed && operand_1[31]) ? (32'd0 - operand_1) : operand_1;
      w_mag2 = (is_signed && operand_2[31]) ? (32'd0 - operand_2) : operand_2;
      // Trial subtract on the shifted remainder; bit 33 is the borrow/sign.
      w_sub  = r_work[64:31] - {2'b00, r_div};
      w_keep = {w_sub[32:0], r_work[30:0], 1'b1};
      w_rest = {r_work[63:0], 1'b0};
      w_next = w_sub[33] ? w_rest : w_keep;
      w_quot = r_qneg ? (32'd0 - w_next[31:0])  : w_next[31:0];
      w_rem  = r_rneg ? (32'd0 - w_next[63:32]) : w_next[63:32];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 6'd0;
         r_work  <= 65'd0;
         r_div   <= 32'd0;
         r_qneg  <= 1'b0;
         r_rneg  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  if (operand_2 == 32'd0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_lo    <= 32'hFFFF_FFFF;
                     r_hi    <= operand_1;
                  end else begin
                     r_state <= S_CALC;
                     r_work  <= {33'd0, w_mag1};
                     r_div   <= w_mag2;
                     r_qneg  <= is_signed & (operand_1[31] ^ operand_2[31]);
                     r_rneg  <= is_signed & operand_1[31];
                     r_cnt   <= 6'd0;
                  end
               end
            end
            S_CALC: begin
               r_work <= w_next;
               r_cnt  <= r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_lo    <= w_quot;
                  r_hi    <= w_rem;
               end
            end
            S_DONE: begin
               // start here still belongs to the finished instruction.
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign stall_req = ((r_state == S_IDLE) & start & ~flush) | (r_state == S_CALC);
   assign done      = r_done;
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule

// File: tb/tb_ex_divider.sv
module tb_ex_divider;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] operand_1;
   logic [31:0] operand_2;
   logic        flush;
   logic        stall_req;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_errors = 0;

   // Expected {hi, lo} per issued divide, popped by the monitor on done.
   logic [63:0] q_exp[$];

   ex_divider dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .operand_1 (operand_1),
      .operand_2 (operand_2),
      .flush     (flush),
      .stall_req (stall_req),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare results whenever the DUT presents done.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q_exp.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1 expected no result at %0t", $time);
         end else begin
            logic [63:0] e;
            e = q_exp.pop_front();
            chk("result_hi", hi, e[63:32]);
            chk("result_lo", lo, e[31:0]);
         end
      end
   end

   // Move to the next cycle: inputs change 1 after the edge, checks 2 after.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue a nonzero divide with start held; ends after the DONE cycle checks
   // with start still high so a follow-on divide can start back-to-back.
   task automatic div_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit scramble);
      next_cycle();
      start = 1'b1; is_signed = sgn; operand_1 = a; operand_2 = b;
      q_exp.push_back({eh, el});
      #1;
      chk("stall_c0", {31'd0, stall_req}, 32'd1);
      for (int c = 1; c <= 32; c++) begin
         next_cycle();
         if (scramble) begin
            operand_1 = $urandom;
            operand_2 = $urandom;
            is_signed = ~is_signed;
         end
         #1;
         if (c == 1 || c == 16 || c == 32) begin
            chk("stall_calc", {31'd0, stall_req}, 32'd1);
            chk("nodone_calc", {31'd0, done}, 32'd0);
         end
      end
      next_cycle();
      #1;
      chk("done_c33", {31'd0, done}, 32'd1);
      chk("stall_c33", {31'd0, stall_req}, 32'd0);
   endtask

   task automatic drop_start();
      next_cycle();
      start = 1'b0;
      #1;
      chk("done_low", {31'd0, done}, 32'd0);
      chk("stall_low", {31'd0, stall_req}, 32'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
      operand_1 = 32'd0; operand_2 = 32'd0;
      #12;
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_stall_idle", {31'd0, stall_req}, 32'd0);
      start = 1'b1;
      #1;
      chk("rst_stall_start", {31'd0, stall_req}, 32'd1);
      start = 1'b0;
      next_cycle();
      rst = 1'b1;

      // DIVU 100 / 7
      div_op(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      drop_start();
      // DIV -7 / 2 and DIVU of the same operands
      div_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      drop_start();
      div_op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);
      drop_start();
      // Signed overflow
      div_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
      drop_start();

      // DIV 5 / 0: done at cycle 1
      next_cycle();
      start = 1'b1; is_signed = 1'b1; operand_1 = 32'd5; operand_2 = 32'd0;
      q_exp.push_back({32'd5, 32'hFFFF_FFFF});
      #1;
      chk("dz_stall_c0", {31'd0, stall_req}, 32'd1);
      next_cycle();
      #1;
      chk("dz_done_c1", {31'd0, done}, 32'd1);
      chk("dz_stall_c1", {31'd0, stall_req}, 32'd0);
      drop_start();

      // Flush at cycle 10 of DIVU 1000 / 3
      next_cycle();
      start = 1'b1; is_signed = 1'b0; operand_1 = 32'd1000; operand_2 = 32'd3;
      for (int c = 1; c <= 10; c++) next_cycle();
      flush = 1'b1;
      #1;
      chk("flush_stall_c10", {31'd0, stall_req}, 32'd1);
      next_cycle();
      flush = 1'b0; start = 1'b0;
      #1;
      chk("flush_stall_c11", {31'd0, stall_req}, 32'd0);
      for (int c = 0; c < 40; c++) begin
         next_cycle();
         #1;
         if (c == 0 || c == 39) begin
            chk("flush_nodone", {31'd0, done}, 32'd0);
            chk("flush_hi_kept", hi, 32'd5);
            chk("flush_lo_kept", lo, 32'hFFFF_FFFF);
         end
      end
      div_op(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);
      drop_start();

      // Back-to-back with operand scrambling during CALC
      div_op(1'b1, 32'd20, 32'd6, 32'd2, 32'd3, 1'b1);
      div_op(1'b1, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
      drop_start();

      // Reset at cycle 15 of a divide
      next_cycle();
      start = 1'b1; is_signed = 1'b0; operand_1 = 32'd77; operand_2 = 32'd5;
      for (int c = 1; c <= 15; c++) next_cycle();
      rst = 1'b0; start = 1'b0;
      #1;
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      next_cycle();
      rst = 1'b1;
      for (int c = 0; c < 40; c++) begin
         next_cycle();
         #1;
         if (c == 0 || c == 20 || c == 39) begin
            chk("postrst_stall", {31'd0, stall_req}, 32'd0);
            chk("postrst_done", {31'd0, done}, 32'd0);
         end
      end

      chk("scoreboard_empty", q_exp.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
